// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions, serializer states and the reset baud divisor.
package uart_defs;

    localparam logic [1:0] TXDATA  = 2'd0;
    localparam logic [1:0] STATUS  = 2'd1;
    localparam logic [1:0] BAUDDIV = 2'd2;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_ACTIVE   = 2;
    localparam int ST_OVERFLOW = 3;

    // 100 MHz / 115200 baud
    localparam int DEFAULT_DIV = 868;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus port of the UART transmitter; rdata is registered inside the peripheral.
interface mmio_uart_tx_if;
    logic        sel;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, we, re, addr, wdata, input rdata);
    modport slave  (input sel, we, re, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout is valid whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a push alongside it is accepted even when full.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, baud divisor and the 8N1 serializer.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first, one bit time each
// STOP  | stop bit (high); chains straight into START when another byte is queued
module mmio_uart_tx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = uart_defs::DEFAULT_DIV,
    parameter int DIV_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    mmio_uart_tx_if.slave bus,
    output logic          tx,
    output logic          busy
);
    import uart_defs::*;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    tx_state_t        state_q, state_n;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] timer_q, timer_n;
    logic [7:0]       shift_q, shift_n;
    logic [2:0]       bit_q, bit_n;
    logic             tx_n;
    logic             tc;
    logic             ovf_q;
    logic [1:0]       reg_sel;
    logic             wr_en;
    logic             rd_en;
    logic             push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [31:0]      status_word;
    logic             unused_bus_bits;

    assign reg_sel = bus.addr[3:2];
    assign wr_en   = bus.sel && bus.we;
    assign rd_en   = bus.sel && bus.re;
    assign push    = wr_en && (reg_sel == TXDATA);
    assign div_eff = (div_q == '0) ? DIV_ONE : div_q;
    assign tc      = (timer_q == '0);

    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata[31:DIV_W]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (fifo_pop),
        .din   (bus.wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The bit timer counts down and reloads from the divisor only at bit boundaries,
    // so a divisor write never truncates the bit in flight.
    always_comb begin
        state_n  = state_q;
        timer_n  = timer_q;
        shift_n  = shift_q;
        bit_n    = bit_q;
        fifo_pop = 1'b0;
        if (state_q == S_IDLE) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shift_n  = fifo_dout;
                timer_n  = div_eff - DIV_ONE;
                state_n  = S_START;
            end
        end else if (!tc) begin
            timer_n = timer_q - DIV_ONE;
        end else begin
            timer_n = div_eff - DIV_ONE;
            if (state_q == S_START) begin
                state_n = S_DATA;
                bit_n   = '0;
            end else if (state_q == S_DATA) begin
                shift_n = {1'b0, shift_q[7:1]};
                if (bit_q == 3'd7) state_n = S_STOP;
                else               bit_n   = bit_q + 3'd1;
            end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shift_n  = fifo_dout;
                state_n  = S_START;
            end else begin
                timer_n = '0;
                state_n = S_IDLE;
            end
        end

        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            shift_q <= '0;
            bit_q   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state_q <= state_n;
            timer_q <= timer_n;
            shift_q <= shift_n;
            bit_q   <= bit_n;
            tx      <= tx_n;
            busy    <= (state_q != S_IDLE) || !fifo_empty;
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[ST_FULL]     = fifo_full;
        status_word[ST_EMPTY]    = fifo_empty;
        status_word[ST_ACTIVE]   = (state_q != S_IDLE);
        status_word[ST_OVERFLOW] = ovf_q;
    end

    // A fresh overflow in the same cycle as a STATUS read wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q     <= DIV_RST;
            ovf_q     <= 1'b0;
            bus.rdata <= '0;
        end else begin
            if (rd_en) begin
                case (reg_sel)
                    STATUS:  bus.rdata <= status_word;
                    BAUDDIV: bus.rdata <= 32'(div_q);
                    default: bus.rdata <= '0;
                endcase
            end
            if (push && fifo_full && !fifo_pop)   ovf_q <= 1'b1;
            else if (rd_en && reg_sel == STATUS)  ovf_q <= 1'b0;
            if (wr_en && reg_sel == BAUDDIV) div_q <= bus.wdata[DIV_W-1:0];
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: a frame-level line model checks tx every cycle,
// plus literal expectations for register reads, latency, busy timing and frame counts.
module tb_mmio_uart_tx;
    localparam int DEPTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx;
    logic busy;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (868),
        .DIV_W       (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          errors = 0;
    int          checks = 0;
    int          model_div = 868;
    bit          model_ovf = 1'b0;
    logic [7:0]  exp_q[$];
    int          start_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int eff(input int d);
        return (d < 1) ? 1 : d;
    endfunction

    // Line model: a frame is start(0), 8 data bits LSB first, stop(1); each bit lasts
    // the divisor in force when that bit begins.
    bit         mon_on = 1'b0;
    int         mon_bit;
    int         mon_left;
    logic [9:0] mon_frame;

    always @(negedge clk) begin
        if (reset) begin
            mon_on = 1'b0;
            exp_q.delete();
            chk("tx_high_in_reset", tx, 1);
        end else begin
            if (mon_on) begin
                if (mon_left == 0) begin
                    mon_bit++;
                    if (mon_bit == 10) mon_on = 1'b0;
                    else               mon_left = eff(model_div) - 1;
                end else begin
                    mon_left--;
                end
            end
            if (!mon_on && tx === 1'b0) begin
                start_cyc.push_back(cyc);
                chk("frame_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_frame = {1'b1, exp_q.pop_front(), 1'b0};
                    mon_on    = 1'b1;
                    mon_bit   = 0;
                    mon_left  = eff(model_div) - 1;
                end
            end
            if (mon_on) chk("tx_line", tx, mon_frame[mon_bit]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic note_write(input logic [3:0] a, input logic [31:0] d);
        if (a[3:2] == 2'd2) model_div = int'(d[15:0]);
        if (a[3:2] == 2'd0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]);
            else                      model_ovf = 1'b1;
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b0; bus.addr = a; bus.wdata = d;
        step(1);
        bus.sel = 1'b0; bus.we = 1'b0;
        note_write(a, d);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.sel = 1'b1; bus.we = 1'b0; bus.re = 1'b1; bus.addr = a;
        step(1);
        bus.sel = 1'b0; bus.re = 1'b0;
        d = bus.rdata;
        if (a[3:2] == 2'd1) model_ovf = 1'b0;
    endtask

    task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, output logic [31:0] rd);
        bus.sel = 1'b1; bus.we = 1'b1; bus.re = 1'b1; bus.addr = a; bus.wdata = wd;
        step(1);
        bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
        rd = bus.rdata;
        note_write(a, wd);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((busy !== 1'b0 || mon_on || exp_q.size() != 0) && n < limit) begin
            step(1);
            n++;
        end
        chk({name, "_drained"}, n < limit, 1);
    endtask

    logic [31:0] d;
    int          s0;
    logic        a5_pat [10];

    initial begin
        a5_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.sel = 1'b0; bus.we = 1'b0; bus.re = 1'b0; bus.addr = '0; bus.wdata = '0;
        #2 reset = 1'b1;
        step(3);
        reset = 1'b0;

        // reset values and register map
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        bus_read(4'h4, d);  chk("rst_status", d, 32'h2);
        step(3);            chk("rdata_holds", bus.rdata, 32'h2);
        bus_read(4'h8, d);  chk("rst_bauddiv", d, 868);
        bus_read(4'h0, d);  chk("txdata_reads_zero", d, 0);
        bus_write(4'h4, 32'hFF);
        bus_write(4'hC, 32'hFF);
        bus_read(4'hC, d);  chk("reserved_reads_zero", d, 0);
        bus_read(4'h4, d);  chk("status_write_ignored", d, 32'h2);

        // simultaneous write+read returns the pre-write value
        bus_rw(4'h8, 32'd4, d); chk("rw_pre_write", d, 868);
        bus_read(4'h8, d);      chk("baud_after_rw", d, 4);

        // single frame 0xA5 at div 4
        bus_write(4'h0, 32'hA5);
        chk("a5_tx_at_write", tx, 1);
        chk("a5_busy_at_write", busy, 0);
        step(1);
        chk("a5_busy_first", busy, 1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("a5_bit%0d", k), tx, a5_pat[k]);
            step(4);
        end
        chk("a5_busy_at_stop_end", busy, 1);
        chk("a5_tx_idle", tx, 1);
        step(1);
        chk("a5_busy_drop", busy, 0);
        wait_idle("a5", 50);

        // back-to-back frames at div 2
        bus_write(4'h8, 32'd2);
        s0 = start_cyc.size();
        bus_write(4'h0, 32'h01);
        bus_write(4'h0, 32'h02);
        bus_write(4'h0, 32'h03);
        step(27);
        bus_read(4'h4, d);  chk("b2b_status_queued", d, 32'h4);
        step(17);
        bus_read(4'h4, d);  chk("b2b_status_empty", d, 32'h6);
        wait_idle("b2b", 200);
        chk("b2b_frames", start_cyc.size() - s0, 3);
        if (start_cyc.size() >= s0 + 3) begin
            chk("b2b_gap1", start_cyc[s0+1] - start_cyc[s0], 20);
            chk("b2b_gap2", start_cyc[s0+2] - start_cyc[s0+1], 20);
        end

        // overflow: one byte pops at once, DEPTH+1 accepted, one dropped
        bus_write(4'h8, 32'd100);
        s0 = start_cyc.size();
        for (int i = 0; i < DEPTH + 2; i++) bus_write(4'h0, 32'h10 + i);
        bus_read(4'h4, d);  chk("ovf_status", d, 32'hD);
        bus_read(4'h4, d);  chk("ovf_cleared", d, 32'h5);
        wait_idle("ovf", 12000);
        chk("ovf_frames", start_cyc.size() - s0, DEPTH + 1);

        // divisor change during data bit 3: 8-cycle bits through bit 3, then 2-cycle bits
        bus_write(4'h8, 32'd8);
        bus_write(4'h0, 32'hFF);
        step(35);
        bus_write(4'h8, 32'd2);
        step(15);
        chk("divchg_busy_at_stop_end", busy, 1);
        step(1);
        chk("divchg_busy_drop", busy, 0);
        wait_idle("divchg", 50);

        // divisor 0 behaves as 1
        bus_write(4'h8, 32'd0);
        bus_write(4'h0, 32'h3C);
        step(1);  chk("div0_start", tx, 0);
        step(1);  chk("div0_bit0", tx, 0);
        step(2);  chk("div0_bit2", tx, 1);
        wait_idle("div0", 50);

        // reset in the middle of a frame with another byte queued
        bus_write(4'h8, 32'd4);
        s0 = start_cyc.size();
        bus_write(4'h0, 32'h00);
        bus_write(4'h0, 32'h55);
        step(8);
        chk("pre_reset_tx_low", tx, 0);
        #2 reset = 1'b1;
        #1 chk("reset_tx_async", tx, 1);
        step(2);
        reset = 1'b0;
        model_div = 868;
        model_ovf = 1'b0;
        chk("mid_rst_rdata", bus.rdata, 0);
        chk("mid_rst_busy", busy, 0);
        bus_read(4'h4, d);  chk("mid_rst_status", d, 32'h2);
        bus_read(4'h8, d);  chk("mid_rst_bauddiv", d, 868);
        step(100);
        chk("mid_rst_no_residual", start_cyc.size() - s0, 1);
        chk("mid_rst_tx_idle", tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench still running at cycle %0d, want finished", cyc);
        $fatal(1);
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the cpu data bus, downstream of the cpu's load/store path.
- Store-word writes queue bytes into a small FIFO. A serializer sends them as 8N1 frames on `tx`.
- Gives the CPU a visible output channel during bring-up and in the CPU_TB-style benches.
- Status and baud divisor are readable and writable through the same bus.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.
- DEFAULT_DIV, 868, reset value of the baud divisor in clocks per bit (100 MHz / 115200).
- DIV_W, 16, width of the baud divisor and bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  bus select; this peripheral is addressed.
- we  in  1  write strobe; qualified by sel.
- re  in  1  read strobe; qualified by sel.
- addr  in  4  byte offset; only addr[3:2] is decoded.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- tx  out  1  serial output; idle high.
- busy  out  1  high while a frame is in flight or the FIFO is non-empty.

Behaviour:
- Reset (async, active-high): tx=1, rdata=0, busy=0, FIFO empty, divisor=DEFAULT_DIV, overflow flag=0, FSM=IDLE, all counters 0.
- Register map, selected by addr[3:2]:
  - 0: TXDATA. A write pushes wdata[7:0]. A read returns 0.
  - 1: STATUS. Read only: bit0 full, bit1 empty, bit2 active (FSM!=IDLE), bit3 overflow, other bits 0. Writes are ignored.
  - 2: BAUDDIV. Read/write, wdata[DIV_W-1:0].
  - 3: reserved. Reads 0; writes are ignored.
- Reads: rdata updates on the clock edge after sel&re, so latency is 1 cycle. rdata holds its value when not reading.
- Read side effect: a read of STATUS clears overflow in the same edge. The read returns the pre-clear value.
- Write to TXDATA when full: the byte is dropped and overflow sets (sticky).
- Write to TXDATA with a pop in the same cycle: the push is accepted even when full; count stays unchanged.
- Simultaneous sel&we&re: the write is performed and rdata returns the pre-write register value.
- Effective divisor = max(BAUDDIV, 1).
- Divisor write during a frame: the bit timer reloads from the new value at the next bit boundary. The current bit is not truncated.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop into the 8-bit shift register, go to START, bit timer=0.
  - START: tx=0 for div cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for div cycles, then shift right. After bit index 7 completes, go to STOP. Bits go out LSB first.
  - STOP: tx=1 for div cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- tx is driven from a register, with no combinational path from the bus.
- Frame length is exactly 10*div cycles. The first start-bit low appears 2 cycles after the write edge: 1 cycle for the FIFO write, 1 for the IDLE pop.
- busy = (FSM!=IDLE) | !empty, registered.
- Reset asserted mid-frame: tx returns high immediately (async). Queued bytes are discarded.

Decomposition:
- Shared package/header `uart_defs`:
  - register offset constants TXDATA=0, STATUS=1, BAUDDIV=2;
  - STATUS bit positions;
  - FSM state encodings (2-bit);
  - DEFAULT_DIV.
- One sub-module, `sync_fifo`:
  - parameterised width/depth;
  - ports push, pop, din, dout, full, empty;
  - count with one extra bit;
  - first-word fall-through so dout is valid while !empty.
- The top level holds register decode, the divisor register, and the serializer FSM.

Test Plan:
- Reset values: pulse reset, then read STATUS -> rdata=0x00000002 (empty), tx=1, busy=0. Read BAUDDIV -> 868.
- Single frame: write BAUDDIV=4, then TXDATA=0xA5. Required response:
  - tx low starts 2 cycles after the write;
  - sampling every 4 cycles gives 0,1,0,1,0,0,1,0,1,1;
  - total frame is 40 cycles; busy drops 1 cycle after the stop bit ends.
- Back-to-back: BAUDDIV=2, write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 20-cycle frames with no idle between stop and start; STATUS empty is set after the third pop.
- Overflow: BAUDDIV=100, write FIFO_DEPTH+2 bytes rapidly.
  - One byte is popped immediately, so FIFO_DEPTH+1 are accepted and 1 is dropped.
  - STATUS reads 0x0D (full|active|overflow); the next STATUS read shows bit3=0.
  - Exactly FIFO_DEPTH+1 frames are transmitted.
- Divisor change mid-frame: BAUDDIV=8, send 0xFF, write BAUDDIV=2 during data bit 3 -> bit 3 lasts 8 cycles, later bits last 2 cycles.
- Mid-frame reset: assert reset during DATA -> tx=1 within the same cycle. After release, STATUS=0x2 and no residual frame is sent.
